rr_decoder_arbiter: RTL and testbench
=====================================

Name: rr_decoder_arbiter

Overview:
- Four-requester round-robin arbiter that shares one downstream resource, selected through a 2-to-4 one-hot decoder.
- Registered 2-bit grant index drives a decoder sub-module; decoder output is the one-hot grant vector.
- Sits between request sources and a shared datapath whose select is one-hot.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per holder when the timeout feature is compiled in (legal range 2..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; low blocks new grants, does not revoke the current one.
- req  input  4  request vector, bit i = requester i, level-sensitive.
- gnt  output  4  one-hot grant; 4'b0000 when no grant.
- gnt_idx  output  2  encoded index of the holder; valid only when gnt_valid=1.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, ptr=00, hold_cnt=0.
- Recovery from reset is synchronous to clk. Reset asserted mid-grant drops gnt immediately with no release handshake.
- ptr is the highest-priority index; search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4 (2-bit wrap 3->0).
- Two states: IDLE and GRANT.
- IDLE, with en=1 and req!=0: pick the first set bit in search order.
  - At the next edge: state=GRANT, gnt_idx=winner, gnt_valid=1, ptr=winner+1.
- IDLE, with en=0 or req=0: stay in IDLE; outputs unchanged (gnt=0000).
- Latency from req rising to gnt: exactly 1 clk.
- GRANT, while req[gnt_idx]=1: hold gnt_idx unchanged, regardless of other requests or en.
- GRANT, when req[gnt_idx]=0 at an edge: release and re-arbitrate in the same edge (back-to-back, no idle bubble).
  - New winner from req with en=1: remain in GRANT, load the new index, ptr=new+1.
  - If en=0 or no requests remain: go to IDLE, gnt=0000, gnt_valid=0.
- gnt is a pure decode of gnt_idx gated by gnt_valid; never more than one bit set.
- Simultaneous release and new request by the same requester at ptr: winner is the lowest-distance set bit from the updated ptr.
  - Example: the holder re-requesting immediately is served last among the pending requesters.
- All outputs are registered except gnt, which is combinational from registered gnt_idx/gnt_valid through the decoder.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt ($clog2(MAX_HOLD+1) bits) clears on every new grant and increments each GRANT cycle.
  - When hold_cnt reaches MAX_HOLD-1 and another requester is pending (with en=1), force release at the next edge.
  - On that edge, grant the next requester in round-robin order and pulse timeout=1 for one cycle.
  - If no other requester is pending, the holder keeps the grant and hold_cnt saturates.
- Undefined: no counter logic; timeout tied 0; grant held until req drops.

Decomposition:
- Package rr_arb_pkg: state encoding (IDLE=1'b0, GRANT=1'b1), NUM_REQ=4, IDX_W=2.
- One sub-module, grant_decoder_2to4 (2-bit index plus enable in, 4-bit one-hot out), purely combinational.
- Arbitration, pointer and counter logic stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with req=1111 -> gnt=0000, gnt_valid=0, timeout=0; release reset -> gnt=0001 after 1 clk.
- Round-robin fairness: req=1111, each holder drops req for 1 cycle after 2 grant cycles -> grant order 0,1,2,3,0 with no idle cycles between grants.
- Wrap-around: grant idx 3, then req=0011 -> next gnt=0001 (idx 0), ptr wraps to 1.
- Enable gating: grant idx 1 active, en=0, req=0110, holder drops -> IDLE, gnt=0000; en=1 -> gnt=0100 after 1 clk.
- Single requester: req=0100 only -> gnt=0100 held indefinitely; with RR_ARB_TIMEOUT_EN and MAX_HOLD=8, no timeout pulse.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=4): req=0011 held constant -> gnt=0001 for 4 cycles, timeout=1 for 1 cycle, gnt=0010 for 4 cycles, repeating.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared encodings and the round-robin search helper for rr_decoder_arbiter.
// The RR_ARB_TIMEOUT_EN macro is consumed by the top module, not by this package.
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;

  // First set bit of req scanning ptr, ptr+1, ... with 2-bit wrap; returns ptr if req is empty
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

endpackage

// File: rtl/grant_decoder_2to4.sv
// Purely combinational 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module grant_decoder_2to4
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  // Decode the index into a single set bit when enabled
  always_comb begin
    onehot = 4'b0000;
    if (en) begin
      case (idx)
        2'd0:    onehot = 4'b0001;
        2'd1:    onehot = 4'b0010;
        2'd2:    onehot = 4'b0100;
        2'd3:    onehot = 4'b1000;
        default: onehot = 4'b0000;
      endcase
    end else begin
      onehot = 4'b0000;
    end
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter with a registered grant index and one-hot decoded grant.
// Optional hold-time limit with forced release is compiled in by defining RR_ARB_TIMEOUT_EN.
module rr_decoder_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic                gnt_valid,
  output logic                timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_decoder_arbiter: MAX_HOLD must be within 2..255");
  end

  logic             state_r;
  logic             state_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] ptr_s;
  logic [IDX_W-1:0] win_s;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0]   hold_cnt_r;
  logic               timeout_r;
  logic               timeout_s;
  logic [NUM_REQ-1:0] others_s;
  logic               expire_s;
  logic [IDX_W-1:0]   force_win_s;
  logic               new_grant_s;

  // gnt is the holder's one-hot while in GRANT, so masking it leaves the competitors
  assign others_s    = req & ~gnt;
  assign expire_s    = en && (hold_cnt_r == HOLD_LAST) && (|others_s);
  assign force_win_s = rr_pick(others_s, ptr_r);
  assign new_grant_s = (state_s == STATE_GRANT) &&
                       ((state_r == STATE_IDLE) || (idx_s != idx_r));
`endif

  assign win_s = rr_pick(req, ptr_r);

  // Next-state, next-index and pointer selection
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    ptr_s   = ptr_r;
`ifdef RR_ARB_TIMEOUT_EN
    timeout_s = 1'b0;
`endif
    case (state_r)
      STATE_IDLE: begin
        if (en && (|req)) begin
          state_s = STATE_GRANT;
          idx_s   = win_s;
          ptr_s   = win_s + IDX_W'(1);
        end else begin
          state_s = STATE_IDLE;
        end
      end
      STATE_GRANT: begin
        if (req[idx_r]) begin
          state_s = STATE_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
          if (expire_s) begin
            idx_s     = force_win_s;
            ptr_s     = force_win_s + IDX_W'(1);
            timeout_s = 1'b1;
          end else begin
            timeout_s = 1'b0;
          end
`endif
        end else if (en && (|req)) begin
          // Release and re-grant on the same edge; ptr already sits past the holder
          state_s = STATE_GRANT;
          idx_s   = win_s;
          ptr_s   = win_s + IDX_W'(1);
        end else begin
          state_s = STATE_IDLE;
        end
      end
      default: begin
        state_s = STATE_IDLE;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STATE_IDLE;
      idx_r   <= 2'd0;
      ptr_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      ptr_r   <= ptr_s;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // Hold counter restarts on each new holder and saturates at the release threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= timeout_s;
      if (new_grant_s) begin
        hold_cnt_r <= '0;
      end else if ((state_r == STATE_GRANT) && (hold_cnt_r != HOLD_LAST)) begin
        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign gnt_idx   = idx_r;
  assign gnt_valid = (state_r == STATE_GRANT);

  grant_decoder_2to4 u_dec (
    .idx    (idx_r),
    .en     (gnt_valid),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed self-checking bench for rr_decoder_arbiter (default MAX_HOLD).
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total;
  int bad;

  rr_decoder_arbiter #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] idx,
                              input logic v);
    check({tag, ".gnt"},       gnt,               g);
    check({tag, ".gnt_idx"},   {2'b00, gnt_idx},  {2'b00, idx});
    check({tag, ".gnt_valid"}, {3'b000, gnt_valid}, {3'b000, v});
    check({tag, ".timeout"},   {3'b000, timeout},   4'b0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1111;

    // Held in reset with every requester active
    tick();
    tick();
    expect_grant("reset", 4'b0000, 2'd0, 1'b0);

    // One clock after reset release requester 0 wins
    rst_n = 1'b1;
    tick();
    expect_grant("first_grant", 4'b0001, 2'd0, 1'b1);

    // Fairness: each holder keeps two cycles, then drops for one edge
    tick();
    expect_grant("rr0_hold", 4'b0001, 2'd0, 1'b1);
    req = 4'b1110; tick();
    expect_grant("rr1", 4'b0010, 2'd1, 1'b1);
    req = 4'b1111; tick();
    expect_grant("rr1_hold", 4'b0010, 2'd1, 1'b1);
    req = 4'b1101; tick();
    expect_grant("rr2", 4'b0100, 2'd2, 1'b1);
    req = 4'b1111; tick();
    expect_grant("rr2_hold", 4'b0100, 2'd2, 1'b1);
    req = 4'b1011; tick();
    expect_grant("rr3", 4'b1000, 2'd3, 1'b1);
    req = 4'b1111; tick();
    expect_grant("rr3_hold", 4'b1000, 2'd3, 1'b1);
    req = 4'b0111; tick();
    expect_grant("rr0_again", 4'b0001, 2'd0, 1'b1);

    // Wrap-around: holder 3, then req=0011 grants 0 and ptr becomes 1
    req = 4'b1000; tick();
    expect_grant("wrap_hold3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0011; tick();
    expect_grant("wrap_to0", 4'b0001, 2'd0, 1'b1);
    req = 4'b1010; tick();
    expect_grant("wrap_ptr1", 4'b0010, 2'd1, 1'b1);

    // Enable gating: en low keeps the holder, blocks the next grant
    en = 1'b0; req = 4'b0110; tick();
    expect_grant("en0_keep", 4'b0010, 2'd1, 1'b1);
    req = 4'b0100; tick();
    expect_grant("en0_idle", 4'b0000, 2'd1, 1'b0);
    tick();
    expect_grant("en0_idle2", 4'b0000, 2'd1, 1'b0);
    en = 1'b1; tick();
    expect_grant("en1_grant", 4'b0100, 2'd2, 1'b1);

    // Single requester keeps the grant well past MAX_HOLD without a timeout
    for (int i = 0; i < 12; i++) begin
      tick();
      expect_grant("single_hold", 4'b0100, 2'd2, 1'b1);
    end

    // Holder 2 releases to 3; its immediate re-request is served after 0 and 1
    req = 4'b1011; tick();
    expect_grant("b2b_to3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0111; tick();
    expect_grant("b2b_to0", 4'b0001, 2'd0, 1'b1);

    // Asynchronous reset mid-grant drops gnt without waiting for a clock
    #2;
    rst_n = 1'b0;
    #1;
    expect_grant("async_rst", 4'b0000, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    expect_grant("idle_noreq", 4'b0000, 2'd0, 1'b0);
    req = 4'b0100; tick();
    expect_grant("post_rst_grant", 4'b0100, 2'd2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
